approx_mul_err_stats: RTL and testbench

- Downstream consumer of the 8x8 unsigned approximate multiplier stage.
- Takes each operand pair together with the approximate product the multiplier produced for it, and forms the exact product internally.
- Accumulates error statistics over a programmed number of samples: sum of error distance (ED), sum of squared ED, max ED and count of erroneous samples.
- Used in hardware evaluation runs to characterise multiplier accuracy without software post-processing.

---
 rtl/approx_mul_pkg.sv | 28 ++
 rtl/approx_mul_err_calc.sv | 39 +++
 rtl/approx_mul_err_stats.sv | 127 ++++++++++++
 tb/tb_approx_mul_err_stats.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Purpose: shared types, widths and helpers for approximate-multiplier evaluation blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int PROD_W = 16;  // 8x8 unsigned product
  localparam int ED_W   = 16;  // |z_approx - x*y| never exceeds 65535
  localparam int SQ_W   = 32;  // ED squared

  // Absolute difference of two unsigned products via a 17-bit signed difference.
  // The magnitude always fits in ED_W bits, because both operands are PROD_W-bit unsigned values.
  function automatic logic [ED_W-1:0] abs_diff17(input logic [PROD_W-1:0] a,
                                                  input logic [PROD_W-1:0] b);
    logic signed [PROD_W:0] d;
    logic signed [PROD_W:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = -d;
    return d[PROD_W] ? m[ED_W-1:0] : d[ED_W-1:0];
  endfunction

endpackage

// File: rtl/approx_mul_err_calc.sv
// Purpose: registered error-distance stage: exact x*y, signed difference to z_approx, |diff|.
// Latency: 1 cycle from in_vld to s1_v/ed.
// Backpressure: none; the caller only pulses in_vld on accepted samples.
// Ports: clk, rst_n (async low); clr drops the pipeline valid; in_vld/x/y/z_approx is the
//        sample in; s1_v/ed is the registered error distance.
module approx_mul_err_calc
  import approx_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [15:0]       z_approx,
  output logic              s1_v,
  output logic [ED_W-1:0]   ed
);

  logic [PROD_W-1:0] exact;

  assign exact = PROD_W'(x) * PROD_W'(y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      ed   <= '0;
    end else if (clr) begin
      s1_v <= 1'b0;
      ed   <= '0;
    end else begin
      s1_v <= in_vld;
      if (in_vld) begin
        ed <= abs_diff17(z_approx, exact);
      end
    end
  end

endmodule

// File: rtl/approx_mul_err_stats.sv
// Purpose: accumulates ED statistics (sum, sum of squares, max, error count) over a programmed run.
// Latency: a sample accepted at edge n is reflected in the results at edge n+1; done rises 2 edges after the last accept.
// Backpressure: in_ready is high only in ACCUM while samples remain; it never depends on in_valid.
// Ports: clk, rst_n (async low); start/num_samples launch a run; in_valid/in_ready/x/y/z_approx
//        is the sample stream; busy/done report progress; sum_ed/sum_sq/max_ed/err_cnt are the results.
module approx_mul_err_stats
  import approx_mul_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            x,
  input  logic [7:0]            y,
  input  logic [15:0]           z_approx,
  output logic                  busy,
  output logic                  done,
  output logic [ED_W+CNT_W-1:0] sum_ed,
  output logic [SQ_W+CNT_W-1:0] sum_sq,
  output logic [ED_W-1:0]       max_ed,
  output logic [CNT_W-1:0]      err_cnt
);

  state_e             state;
  logic [CNT_W-1:0]   accepted;
  logic [CNT_W-1:0]   num_q;
  logic               accept;
  logic               start_ok;
  logic               s1_v;
  logic [ED_W-1:0]    ed;
  logic [SQ_W-1:0]    ed_sq;

  assign in_ready = (state == ACCUM) && (accepted < num_q);
  assign accept   = in_valid && in_ready;
  // start is only honoured between runs; the same pulse clears the pipeline and results
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign ed_sq    = SQ_W'(ed) * SQ_W'(ed);

  approx_mul_err_calc u_calc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .in_vld   (accept),
    .x        (x),
    .y        (y),
    .z_approx (z_approx),
    .s1_v     (s1_v),
    .ed       (ed)
  );

  // Run control; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      accepted <= '0;
      num_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_q    <= num_samples;
            accepted <= '0;
            if (num_samples == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ACCUM;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            accepted <= accepted + CNT_W'(1);
            if (accepted == num_q - CNT_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // s1_v low means the last sample's stage-2 update has already been written
          if (!s1_v) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: accumulators are wide enough for 2^CNT_W-1 worst-case samples, so no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed  <= '0;
      sum_sq  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (start_ok) begin
      sum_ed  <= '0;
      sum_sq  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (s1_v) begin
      sum_ed  <= sum_ed + (ED_W+CNT_W)'(ed);
      sum_sq  <= sum_sq + (SQ_W+CNT_W)'(ed_sq);
      if (ed > max_ed) begin
        max_ed <= ed;
      end
      err_cnt <= err_cnt + CNT_W'(ed != '0);
    end
  end

endmodule

// File: tb/tb_approx_mul_err_stats.sv
// Purpose: directed self-checking bench for approx_mul_err_stats with a run-level reference model.
// Latency: model expects results one edge after an accept and done two edges after the last accept.
// Backpressure: stimulus holds each sample until in_ready accepts it, bounded by a cycle budget.
module tb_approx_mul_err_stats;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_samples = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        x = '0;
  logic [7:0]        y = '0;
  logic [15:0]       z_approx = '0;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [16+CNT_W-1:0] sum_ed;
  logic [32+CNT_W-1:0] sum_sq;
  logic [15:0]       max_ed;
  logic [CNT_W-1:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  approx_mul_err_stats #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy), .done(done), .sum_ed(sum_ed), .sum_sq(sum_sq),
    .max_ed(max_ed), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a run is a list of (edge index, ED) accepts ----------------
  bit      m_started = 1'b0;
  int      m_n = 0;
  int      m_cnt = 0;
  longint  m_edge = 0;
  longint  acc_edge[$];
  int      acc_ed[$];

  function automatic bit m_in_ready();
    return m_started && (m_cnt < m_n);
  endfunction

  function automatic bit m_done();
    if (!m_started) return 1'b0;
    if (m_n == 0) return 1'b1;
    return (m_cnt == m_n) && (acc_edge[$] <= m_edge - 2);
  endfunction

  function automatic bit m_busy();
    return m_started && !m_done();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0;
      m_n = 0;
      m_cnt = 0;
      acc_edge.delete();
      acc_ed.delete();
    end else begin
      bit rdy;
      bit bsy;
      int ex;
      int ea;
      rdy = m_in_ready();
      bsy = m_busy();
      m_edge++;
      if (start && !bsy) begin
        m_started = 1'b1;
        m_n = int'(num_samples);
        m_cnt = 0;
        acc_edge.delete();
        acc_ed.delete();
      end else if (in_valid && rdy) begin
        ex = int'(x) * int'(y);
        ea = int'(z_approx) - ex;
        if (ea < 0) ea = -ea;
        acc_edge.push_back(m_edge);
        acc_ed.push_back(ea);
        m_cnt++;
      end
    end
  end

  // One compare process: every negedge out of reset, DUT must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      longint e_sum;
      longint e_sq;
      longint e_max;
      longint e_err;
      e_sum = 0; e_sq = 0; e_max = 0; e_err = 0;
      for (int i = 0; i < acc_ed.size(); i++) begin
        if (acc_edge[i] <= m_edge - 1) begin
          e_sum += acc_ed[i];
          e_sq  += longint'(acc_ed[i]) * longint'(acc_ed[i]);
          if (acc_ed[i] > e_max) e_max = acc_ed[i];
          if (acc_ed[i] != 0) e_err++;
        end
      end
      chk("cyc_in_ready", longint'(in_ready), longint'(m_in_ready()));
      chk("cyc_busy",     longint'(busy),     longint'(m_busy()));
      chk("cyc_done",     longint'(done),     longint'(m_done()));
      chk("cyc_sum_ed",   longint'(sum_ed),   e_sum);
      chk("cyc_sum_sq",   longint'(sum_sq),   e_sq);
      chk("cyc_max_ed",   longint'(max_ed),   e_max);
      chk("cyc_err_cnt",  longint'(err_cnt),  e_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Present one sample until accepted; returns right after the accepting edge.
  task automatic send(input int xv, input int yv, input int zv);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    x = 8'(xv); y = 8'(yv); z_approx = 16'(zv);
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_results(input string nm, input longint se, input longint sq,
                             input longint mx, input longint ec);
    chk({nm, "_sum_ed"},  longint'(sum_ed),  se);
    chk({nm, "_sum_sq"},  longint'(sum_sq),  sq);
    chk({nm, "_max_ed"},  longint'(max_ed),  mx);
    chk({nm, "_err_cnt"}, longint'(err_cnt), ec);
  endtask

  initial begin
    int s;
    int rdy_after;
    // reset state
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk_results("rst", 0, 0, 0, 0);

    // single sample: 3*5=15, z=12 -> ED 3; done two edges after the accept
    do_start(1);
    send(3, 5, 12);
    @(negedge clk); chk("t1_done_e0", longint'(done), 0);
    @(negedge clk); chk("t1_done_e1", longint'(done), 0);
    @(negedge clk); chk("t1_done_e2", longint'(done), 1);
    chk_results("t1", 3, 9, 3, 1);

    // boundary products: EDs 0, 510, 7
    do_start(3);
    send(255, 255, 65025);
    send(255, 255, 65535);
    send(0, 0, 7);
    wait_done();
    chk_results("t2", 517, 260149, 510, 2);

    // streaming with gaps; only 4 of the presented samples may be taken (EDs 0..3)
    do_start(4);
    s = 0;
    rdy_after = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      x = 8'(s + 2); y = 8'd3; z_approx = 16'((s + 2) * 3 + s);
      if (s >= 4 && in_ready) rdy_after++;
      if (in_valid && in_ready) begin
        tick();
        s++;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    chk("t3_accepts", s, 4);
    chk("t3_ready_after_4th", rdy_after, 0);
    wait_done();
    chk_results("t3", 6, 14, 3, 3);

    // zero-length run: DONE on the next cycle with cleared results
    do_start(0);
    #3;
    chk("t4_done", longint'(done), 1);
    chk("t4_in_ready", longint'(in_ready), 0);
    chk_results("t4", 0, 0, 0, 0);

    // start during ACCUM ignored; run of 2 gives ED 10 and 0
    do_start(2);
    send(10, 10, 90);
    start = 1'b1; num_samples = CNT_W'(7);
    tick();
    start = 1'b0;
    send(2, 2, 4);
    wait_done();
    chk_results("t5", 10, 100, 10, 1);
    // restart from DONE clears old results
    do_start(1);
    send(1, 1, 1);
    wait_done();
    chk_results("t6", 0, 0, 0, 0);

    // reset mid-ACCUM after 3 samples
    do_start(5);
    send(4, 4, 20);
    send(5, 5, 20);
    send(6, 6, 30);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_async_busy", longint'(busy), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_in_ready", longint'(in_ready), 0);
    chk("t7_busy", longint'(busy), 0);
    chk("t7_done", longint'(done), 0);
    chk_results("t7", 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
